// File: rtl/mac_dot_engine.sv
// Streaming dot-product engine: takes VEC_LEN (a,b) pairs over valid/ready,
// multiplies through one registered product stage, accumulates, and presents
// the sum on a valid/ready output before clearing itself for the next vector.
// Optional feature macro: MAC_DOT_SATURATE_EN (saturating adds, sticky ovf).
module mac_dot_engine #(
  parameter int unsigned DW      = 8,
  parameter int unsigned VEC_LEN = 16,
  parameter int unsigned ACCW    = 24,
  parameter int unsigned SIGNED  = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ACCW-1:0] result,
  output logic            ovf,
  output logic            busy
);

  localparam int unsigned PW = 2 * DW;
  localparam int unsigned CW = $clog2(VEC_LEN + 1);

  typedef enum logic [1:0] {StIdle, StAccum, StDrain, StDone} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q;
  logic [PW-1:0]   p_q;
  logic            p_vld_q;
  logic [ACCW-1:0] acc_q;

  logic            accept;
  logic            done_hs;
  logic [PW-1:0]   a_ext, b_ext, prod;
  logic [ACCW-1:0] p_ext;
  logic [ACCW-1:0] add_val;
  logic            add_ovf;
  logic            ext_bit;

  // A pair presented alongside clear is dropped.
  assign accept  = in_valid && in_ready && !clear;
  assign done_hs = (state_q == StDone) && out_ready;

  // Operands widened to the product width; the low PW bits of the product are
  // then correct for both unsigned and two's-complement operands.
  always_comb begin
    a_ext = {{DW{(SIGNED != 0) & a[DW-1]}}, a};
    b_ext = {{DW{(SIGNED != 0) & b[DW-1]}}, b};
    prod  = a_ext * b_ext;
  end

  assign ext_bit = (SIGNED != 0) & p_q[PW-1];

  if (ACCW > PW) begin : g_ext
    assign p_ext = {{(ACCW - PW){ext_bit}}, p_q};
  end else begin : g_noext
    assign p_ext = p_q[ACCW-1:0];
  end

`ifdef MAC_DOT_SATURATE_EN
  logic [ACCW:0] sum;
  logic          ovf_q;

  // Add with clamp to the representable range of the accumulator.
  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, p_ext};
    add_val = sum[ACCW-1:0];
    add_ovf = 1'b0;
    if (SIGNED != 0) begin
      if ((acc_q[ACCW-1] == p_ext[ACCW-1]) && (sum[ACCW-1] != acc_q[ACCW-1])) begin
        add_ovf = 1'b1;
        add_val = acc_q[ACCW-1] ? {1'b1, {(ACCW - 1){1'b0}}} : {1'b0, {(ACCW - 1){1'b1}}};
      end
    end else if (sum[ACCW]) begin
      add_ovf = 1'b1;
      add_val = '1;
    end
  end

  assign ovf = ovf_q;
`else
  // Plain modulo-2^ACCW add.
  always_comb begin
    add_val = acc_q + p_ext;
    add_ovf = 1'b0;
  end

  assign ovf = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StAccum;
      StAccum: if (accept && (count_q == CW'(VEC_LEN - 1))) state_d = StDrain;
      StDrain: state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, counter, product stage and accumulator registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      count_q <= '0;
      p_q     <= '0;
      p_vld_q <= 1'b0;
      acc_q   <= '0;
`ifdef MAC_DOT_SATURATE_EN
      ovf_q   <= 1'b0;
`endif
    end else if (clear) begin
      state_q <= StIdle;
      count_q <= '0;
      p_vld_q <= 1'b0;
      acc_q   <= '0;
`ifdef MAC_DOT_SATURATE_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      p_vld_q <= accept;
      if (accept) p_q <= prod;
      if (done_hs) begin
        count_q <= '0;
        acc_q   <= '0;
`ifdef MAC_DOT_SATURATE_EN
        ovf_q   <= 1'b0;
`endif
      end else begin
        if (accept) count_q <= count_q + 1'b1;
        if (p_vld_q) begin
          acc_q <= add_val;
`ifdef MAC_DOT_SATURATE_EN
          ovf_q <= ovf_q | add_ovf;
`endif
        end
      end
    end
  end

`ifndef MAC_DOT_SATURATE_EN
  logic unused_add_ovf;
  assign unused_add_ovf = add_ovf;
`endif

  assign in_ready  = (state_q == StIdle) || (state_q == StAccum);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign result    = acc_q;

endmodule

// File: tb/tb_mac_dot_engine.sv
// Directed bench for mac_dot_engine. Three instances share one stimulus:
// unsigned ACCW=24, signed ACCW=24, and unsigned ACCW=16 (overflow case).
module tb_mac_dot_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic        out_ready;
  logic [7:0]  a, b;

  logic        ir_u, ov_u, ovf_u, busy_u;
  logic [23:0] res_u;
  logic        ir_s, ov_s, ovf_s, busy_s;
  logic [23:0] res_s;
  logic        ir_w, ov_w, ovf_w, busy_w;
  logic [15:0] res_w;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mac_dot_engine #(.DW(8), .VEC_LEN(4), .ACCW(24), .SIGNED(0)) u_dut_u (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(ir_u),
    .a(a), .b(b), .out_valid(ov_u), .out_ready(out_ready), .result(res_u),
    .ovf(ovf_u), .busy(busy_u)
  );

  mac_dot_engine #(.DW(8), .VEC_LEN(4), .ACCW(24), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(ir_s),
    .a(a), .b(b), .out_valid(ov_s), .out_ready(out_ready), .result(res_s),
    .ovf(ovf_s), .busy(busy_s)
  );

  mac_dot_engine #(.DW(8), .VEC_LEN(4), .ACCW(16), .SIGNED(0)) u_dut_w (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(ir_w),
    .a(a), .b(b), .out_valid(ov_w), .out_ready(out_ready), .result(res_w),
    .ovf(ovf_w), .busy(busy_w)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Present one pair for exactly one edge; in_ready is 1 in IDLE/ACCUM.
  task automatic push(input logic [7:0] av, input logic [7:0] bv);
    a = av;
    b = bv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  // Called just after the last accept: DRAIN this cycle, DONE after the next edge.
  task automatic drain(input string tag);
    check_eq({tag, "_drain_ov"}, 32'(ov_u), 32'd0);
    check_eq({tag, "_drain_ir"}, 32'(ir_u), 32'd0);
    @(posedge clk);
    #1;
    check_eq({tag, "_lat"}, 32'(ov_u), 32'd1);
    for (int i = 0; i < 8 && !ov_u; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq({tag, "_hs_ov"}, 32'(ov_u), 32'd0);
    check_eq({tag, "_hs_busy"}, 32'(busy_u), 32'd0);
    check_eq({tag, "_hs_acc"}, 32'(res_u), 32'd0);
  endtask

  task automatic ones_vec(input string tag);
    for (int i = 0; i < 4; i++) push(8'd1, 8'd1);
    drain(tag);
    check_eq({tag, "_res"}, 32'(res_u), 32'd4);
    check_eq({tag, "_ovf"}, 32'(ovf_u), 32'd0);
    handshake(tag);
  endtask

  initial begin
    rst       = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #1;
    check_eq("rst_res", 32'(res_u), 32'd0);
    check_eq("rst_ov", 32'(ov_u), 32'd0);
    check_eq("rst_ovf", 32'(ovf_u), 32'd0);
    check_eq("rst_busy", 32'(busy_u), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    check_eq("rst_ir", 32'(ir_u), 32'd1);

    // T1 back-to-back 1..4 x 2 = 20
    for (int i = 1; i <= 4; i++) push(8'(i), 8'd2);
    drain("t1");
    check_eq("t1_res_u", 32'(res_u), 32'd20);
    check_eq("t1_res_s", 32'(res_s), 32'd20);
    check_eq("t1_res_w", 32'(res_w), 32'd20);

    // T2 consumer stalls for 5 cycles
    for (int i = 0; i < 5; i++) begin
      idle_cycle();
      check_eq("t2_hold_res", 32'(res_u), 32'd20);
      check_eq("t2_hold_ir", 32'(ir_u), 32'd0);
      check_eq("t2_hold_ov", 32'(ov_u), 32'd1);
    end
    handshake("t2");
    ones_vec("t2_ones");

    // T3 bubbles between pairs
    push(8'd1, 8'd2);
    idle_cycle();
    push(8'd2, 8'd2);
    idle_cycle();
    check_eq("t3_mid_busy", 32'(busy_u), 32'd1);
    check_eq("t3_mid_ir", 32'(ir_u), 32'd1);
    push(8'd3, 8'd2);
    idle_cycle();
    check_eq("t3_mid_ov", 32'(ov_u), 32'd0);
    push(8'd4, 8'd2);
    drain("t3");
    check_eq("t3_res", 32'(res_u), 32'd20);
    handshake("t3");

    // T4 signed operands
    for (int i = 0; i < 4; i++) push(8'h80, 8'h80);
    drain("t4a");
    check_eq("t4a_res_s", 32'(res_s), 32'd65536);
    check_eq("t4a_res_u", 32'(res_u), 32'd65536);
    handshake("t4a");
    for (int i = 0; i < 4; i++) push(8'hFD, 8'd5);
    drain("t4b");
    check_eq("t4b_res_s", 32'(res_s), 32'h00FF_FFC4);
    check_eq("t4b_ovf_s", 32'(ovf_s), 32'd0);
    check_eq("t4b_res_u", 32'(res_u), 32'd5060);
    handshake("t4b");

    // T5 abort by clear; the pair presented with clear must be dropped
    push(8'd1, 8'd1);
    push(8'd1, 8'd1);
    a = 8'd1;
    b = 8'd1;
    in_valid = 1'b1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    in_valid = 1'b0;
    check_eq("t5_clr_busy", 32'(busy_u), 32'd0);
    check_eq("t5_clr_acc", 32'(res_u), 32'd0);
    ones_vec("t5_clr");

    // T5 same again with an asynchronous reset pulse
    push(8'd1, 8'd1);
    push(8'd1, 8'd1);
    rst = 1'b0;
    #1;
    check_eq("t5_rst_busy", 32'(busy_u), 32'd0);
    check_eq("t5_rst_acc", 32'(res_u), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    ones_vec("t5_rst");

    // T6 255*255 x4 overflows a 16-bit accumulator
    for (int i = 0; i < 4; i++) push(8'hFF, 8'hFF);
    drain("t6");
    check_eq("t6_res_u", 32'(res_u), 32'd260100);
    check_eq("t6_res_s", 32'(res_s), 32'd4);
`ifdef MAC_DOT_SATURATE_EN
    check_eq("t6_res_w", 32'(res_w), 32'd65535);
    check_eq("t6_ovf_w", 32'(ovf_w), 32'd1);
`else
    check_eq("t6_res_w", 32'(res_w), 32'd63492);
    check_eq("t6_ovf_w", 32'(ovf_w), 32'd0);
`endif
    check_eq("t6_ovf_u", 32'(ovf_u), 32'd0);
    handshake("t6");
    check_eq("t6_ovf_w_clr", 32'(ovf_w), 32'd0);
    check_eq("t6_res_w_clr", 32'(res_w), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
